// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic unit:
// op-code width and the eight logic op codes.
package logic_pkg;

  localparam int LOGIC_OP_W = 3;

  localparam logic [LOGIC_OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [LOGIC_OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [LOGIC_OP_W-1:0] OP_NOT   = 3'd2;
  localparam logic [LOGIC_OP_W-1:0] OP_XOR   = 3'd3;
  localparam logic [LOGIC_OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [LOGIC_OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [LOGIC_OP_W-1:0] OP_XNOR  = 3'd6;
  localparam logic [LOGIC_OP_W-1:0] OP_PASSB = 3'd7;

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit logic function selector.
// Replaces the old per-gate AND/OR/NOT cells.
module logic_op_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [LOGIC_OP_W-1:0] op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      y
);

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == OP_AND):   y = a & b;
      (op == OP_OR):    y = a | b;
      (op == OP_NOT):   y = ~a;
      (op == OP_XOR):   y = a ^ b;
      (op == OP_NAND):  y = ~(a & b);
      (op == OP_NOR):   y = ~(a | b);
      (op == OP_XNOR):  y = ~(a ^ b);
      (op == OP_PASSB): y = b;
      default:          y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Two-stage streamed bitwise logic unit with operand
// chaining, valid/ready flow control and result flags.
module bitwise_logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [LOGIC_OP_W-1:0] in_op,
  input  logic                  in_chain,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_y,
  output logic                  out_zero,
  output logic                  out_ones,
  output logic                  out_parity
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic [WIDTH-1:0] chain_q, chain_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;

  logic             s2_ready;
  logic             s1_ready;
  logic             accept;
  logic             s1_adv;
  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] op_y;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;
  assign accept   = in_valid && s1_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign eff_a    = in_chain ? chain_q : in_a;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op (in_op),
    .a  (eff_a),
    .b  (in_b),
    .y  (op_y)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    chain_d    = chain_q;
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    zero_d     = zero_q;
    ones_d     = ones_q;
    parity_d   = parity_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_y_d     = op_y;
      chain_d    = op_y;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
    end
    // flags travel with the word so they stay stable under stall
    if (s1_adv) begin
      s2_y_d   = s1_y_q;
      zero_d   = ~|s1_y_q;
      ones_d   = &s1_y_q;
      parity_d = ^s1_y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      chain_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      zero_q     <= 1'b1;
      ones_q     <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      chain_q    <= chain_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      zero_q     <= zero_d;
      ones_q     <= ones_d;
      parity_q   <= parity_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_y      = s2_y_q;
  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = parity_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Testbench for bitwise_logic_unit: directed scenarios plus
// randomized traffic against a truth-table reference model.
module tb_bitwise_logic_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_chain;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       out_valid, out_ready;
  logic [7:0] out_y;
  logic       out_zero, out_ones, out_parity;

  logic       v1, ir1, ch1, ov1, ordy1;
  logic [0:0] a1, b1, y1;
  logic [2:0] op1;
  logic       z1, o1, p1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] chain_m;

  always #5 clk = ~clk;

  bitwise_logic_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_chain(in_chain),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero),
    .out_ones(out_ones), .out_parity(out_parity)
  );

  bitwise_logic_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .in_op(op1),
    .in_chain(ch1),
    .out_valid(ov1), .out_ready(ordy1),
    .out_y(y1), .out_zero(z1),
    .out_ones(o1), .out_parity(p1)
  );

  // per-op truth table indexed by {a_bit, b_bit}
  function automatic logic [7:0] model(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [3:0] tt [8];
    logic [7:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110;
    tt[2] = 4'b0011; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001;
    tt[6] = 4'b1001; tt[7] = 4'b1010;
    for (int i = 0; i < 8; i++)
      r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  task automatic cyc(
    input  logic       v,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    input  logic       ch,
    input  logic       ordy,
    output logic       acc,
    output logic       fire,
    output logic [7:0] y,
    output logic       z,
    output logic       o,
    output logic       p
  );
    logic [7:0] r;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b;
    in_op = op; in_chain = ch; out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    y = out_y; z = out_zero; o = out_ones; p = out_parity;
    if (acc) begin
      r = model(op, ch ? chain_m : a, b);
      chain_m = r;
      exp_q.push_back(r);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] y,
                         input logic z, input logic o, input logic p);
    logic [7:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected output y=%h", nm, y);
    end else begin
      e = exp_q.pop_front();
      if ({y, z, o, p} !== {e, e == 8'h00, e == 8'hFF,
                            1'($countones(e) % 2)}) begin
        fails++;
        $display("FAIL %s: got y=%h z%b o%b p%b, want y=%h", nm,
                 y, z, o, p, e);
      end
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({out_valid, out_y, out_zero, out_ones, out_parity}
        !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: v%b y=%h z%b o%b p%b, want v0 y=00 z1",
               out_valid, out_y, out_zero, out_ones, out_parity);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic acc, f, z, o, p;
    logic [7:0] y;
    cyc(1, 8'hF0, 8'h3C, 3'd0, 0, 1, acc, f, y, z, o, p);
    cyc(0, 8'h00, 8'h00, 3'd0, 0, 1, acc, f, y, z, o, p);
    tests++;
    if (f !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency: out_valid=%b at +1 want 0", f);
    end
    cyc(0, 8'h00, 8'h00, 3'd0, 0, 1, acc, f, y, z, o, p);
    tests++;
    if ({f, y, z, o, p} !== {1'b1, 8'h30, 3'b000}) begin
      fails++;
      $display("FAIL basic_and: v%b y=%h z%b o%b p%b want v1 y=30 000",
               f, y, z, o, p);
    end
    if (f) void'(exp_q.pop_front());
  endtask

  task automatic test_all_ops;
    logic acc, f, z, o, p;
    logic [7:0] y;
    logic [7:0] want [8];
    want = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h3C};
    for (int i = 0; i < 11; i++) begin
      cyc(i < 8, 8'hF0, 8'h3C, 3'(i), 0, 1, acc, f, y, z, o, p);
      tests++;
      if (f !== (i >= 2 && i < 10)) begin
        fails++;
        $display("FAIL all_ops_timing: cycle %0d valid=%b", i, f);
      end
      if (f && i >= 2 && i < 10) begin
        tests++;
        if (y !== want[i-2]) begin
          fails++;
          $display("FAIL all_ops_op%0d: y=%h want %h", i - 2, y,
                   want[i-2]);
        end
        chk_out("all_ops_model", y, z, o, p);
      end
    end
  endtask

  task automatic test_chain;
    logic acc, f, z, o, p;
    logic [7:0] y;
    logic [7:0] bs [3];
    logic [2:0] ops [3];
    logic [7:0] want [3];
    int n;
    bs = '{8'h02, 8'h03, 8'h00};
    ops = '{3'd1, 3'd3, 3'd2};
    want = '{8'h03, 8'h00, 8'hFF};
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 3, 8'h01, i < 3 ? bs[i] : 8'h00, i < 3 ? ops[i] : 3'd0,
          i > 0, 1, acc, f, y, z, o, p);
      if (f) begin
        tests++;
        if (n > 2 || y !== want[n] || z !== (n == 1) || o !== (n == 2))
        begin
          fails++;
          $display("FAIL chain_%0d: y=%h z%b o%b", n, y, z, o);
        end
        chk_out("chain_model", y, z, o, p);
        n++;
      end
    end
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL chain_count: got %0d results want 3", n);
    end
  endtask

  task automatic test_backpressure;
    logic acc, f, z, o, p;
    logic [7:0] y;
    int n;
    cyc(1, 8'hF0, 8'h3C, 3'd0, 0, 0, acc, f, y, z, o, p);
    cyc(1, 8'hAA, 8'h0F, 3'd1, 0, 0, acc, f, y, z, o, p);
    tests++;
    if (acc !== 1'b1) begin
      fails++;
      $display("FAIL bp_second_accept: acc=%b want 1", acc);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h55, 8'hFF, 3'd3, 0, 0, acc, f, y, z, o, p);
      tests++;
      if ({acc, out_valid, y, z, o, p} !== {2'b01, 8'h30, 3'b000}) begin
        fails++;
        $display("FAIL bp_hold: in_ready=%b valid=%b y=%h want 0 1 30",
                 acc, out_valid, y);
      end
    end
    n = 0;
    cyc(1, 8'h55, 8'hFF, 3'd3, 0, 1, acc, f, y, z, o, p);
    tests++;
    if ({acc, f} !== 2'b11) begin
      fails++;
      $display("FAIL bp_release: acc=%b fire=%b want 11", acc, f);
    end
    if (f) begin chk_out("bp_out", y, z, o, p); n++; end
    for (int i = 0; i < 10 && n < 3; i++) begin
      cyc(0, 8'h00, 8'h00, 3'd0, 0, 1, acc, f, y, z, o, p);
      if (f) begin chk_out("bp_out", y, z, o, p); n++; end
    end
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL bp_count: got %0d results want 3", n);
    end
  endtask

  task automatic test_reset_mid;
    logic acc, f, z, o, p;
    logic [7:0] y;
    int n;
    cyc(1, 8'hFF, 8'hFF, 3'd0, 0, 0, acc, f, y, z, o, p);
    cyc(1, 8'hFF, 8'h7F, 3'd1, 0, 0, acc, f, y, z, o, p);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_y, out_zero} !== {1'b0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid: v%b y=%h z%b want v0 y=00 z1",
               out_valid, out_y, out_zero);
    end
    exp_q.delete();
    chain_m = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0, 8'hFF, 8'h05, 3'd1, 1, 1, acc, f, y, z, o, p);
      if (f) begin
        n++;
        tests++;
        if (y !== 8'h05) begin
          fails++;
          $display("FAIL reset_chain: y=%h want 05", y);
        end
        chk_out("reset_chain_model", y, z, o, p);
      end
    end
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL reset_count: got %0d results want 1", n);
    end
  endtask

  task automatic test_width1;
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b0; op1 = 3'd6; ordy1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({ov1, y1, o1, p1, z1} !== 5'b11110) begin
      fails++;
      $display("FAIL width1_xnor: v%b y%b o%b p%b z%b want 1 1 1 1 0",
               ov1, y1, o1, p1, z1);
    end
  endtask

  task automatic test_random;
    logic acc, f, z, o, p;
    logic [7:0] y;
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
          3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
          acc, f, y, z, o, p);
      if (f) chk_out("random", y, z, o, p);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      cyc(0, 8'h00, 8'h00, 3'd0, 0, 1, acc, f, y, z, o, p);
      if (f) chk_out("random_drain", y, z, o, p);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL random_drain: %0d results missing", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0;
    in_chain = 0; out_ready = 1;
    v1 = 0; a1 = 0; b1 = 0; op1 = 0; ch1 = 0; ordy1 = 1;
    chain_m = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_basic();
    test_all_ops();
    test_chain();
    test_backpressure();
    test_reset_mid();
    test_width1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, pipelined bitwise logic unit that computes one of eight two-operand logic functions on WIDTH-bit words. It supports valid/ready flow control, an operand-chaining mode and registered result flags. It is the next-generation replacement for the single-bit AND/OR/NOT gate cells wherever multi-bit, streamed logic operations are needed in the datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  input transaction present
- in_ready  output  1  unit accepts the input this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation code (see Operation)
- in_chain  input  1  1 = replace A with the previous result
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result this cycle
- out_y  output  WIDTH  result word
- out_zero  output  1  out_y == 0
- out_ones  output  1  out_y is all ones
- out_parity  output  1  XOR-reduction of out_y

## Operation
- Op codes: 0 AND, 1 OR, 2 NOT A (B ignored), 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS B (A ignored).
- Effective A: chain_q when in_chain=1, otherwise in_a.
- Accept: in_valid && in_ready.
- Stage 1, on accept:
  - s1_y <= f(op, effective A, in_b).
  - chain_q <= the same value.
  - s1_valid <= 1.
- chain_q therefore always holds the result of the most recently accepted transaction, so chaining back-to-back transactions has no hazard.
- Stage 2, on stage-2 load:
  - s2_y <= s1_y.
  - Flags are computed from s1_y and registered alongside it.
  - out_* are driven directly from the stage-2 registers.
- Flow control (combinational ready chain):
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready
- Stage 1 advances into stage 2 when s1_valid && s2_ready. Stage 1 is cleared unless a new accept happens in the same cycle.
- While out_valid=1 && out_ready=0, out_y and all flags must stay stable and nothing is dropped or duplicated.
- in_op values are all defined; there is no illegal-op case.
- WIDTH=1 must work: out_zero = !out_y and out_ones = out_parity = out_y.
- No arithmetic; all results are exactly WIDTH bits with no extension.

## Timing
- Reset (rst_n=0, takes effect immediately):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_y=0, out_zero=1, out_ones=0, out_parity=0.
  - chain_q=0.
  - in_ready=1 from the first cycle after release.
- Latency: a transaction accepted at edge k appears with out_valid=1 after edge k+1.
- Throughput: one transaction per cycle with out_ready held at 1.
- Capacity: two transactions in flight. in_ready drops only when both stages are valid and out_ready=0.
- Simultaneous drain and accept: stage 1 hands over to stage 2 and loads the new input on the same edge.
- Reset mid-operation: in-flight transactions are discarded, with no partial output after release.
- Combinational paths:
  - out_ready -> in_ready is the only combinational path.
  - No combinational path from in_* data to out_*.

## Structure
- Shared package logic_pkg holds:
  - LOGIC_OP_W = 3.
  - The eight op-code localparams (OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_PASSB).
- Sub-module logic_op_core: purely combinational, parametrised WIDTH, inputs op/a/b, output y. It replaces the old per-gate cells.
- Top module holds: the two pipeline stages, chain_q, flag generation and the ready chain.

## Test plan
- Basic op: WIDTH=8, accept A=8'hF0, B=8'h3C, op=AND -> two cycles later out_y=8'h30, out_zero=0, out_ones=0, out_parity=0.
- All ops: same operands, ops 0..7 issued back to back -> results F0/3C give 30, FC, 0F, CC, CF, 03, 33, 3C, one per cycle, with no bubbles.
- Chaining: op=OR A=8'h01 B=8'h02, then op=XOR chain=1 B=8'h03, then op=NOT chain=1 -> out_y sequence 8'h03, 8'h00, 8'hFF. The last has out_ones=1, and the middle one has out_zero=1.
- Backpressure: issue 3 transactions with out_ready=0 -> in_ready goes 0 after 2 accepts and out_y holds the first result. Then release out_ready -> all 3 results arrive in order.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid drops immediately and out_y=0, out_zero=1. A subsequent chain=1 transaction uses A=0.
- Width corner: WIDTH=1, op=XNOR A=0 B=0 -> out_y=1, out_ones=1, out_parity=1, out_zero=0.
